nibble_serial_adder: RTL and testbench

NIBBLE_SERIAL_ADDER -- requirements
Module: nibble_serial_adder

---
 rtl/nibble_serial_adder.sv | 112 +++++++++++
 tb/tb_nibble_serial_adder.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_adder.sv
// Bit-serial-by-nibble adder: one 4-bit carry-lookahead slice is reused over
// NIBBLES cycles, least significant nibble first, behind a valid/ready handshake.
module nibble_serial_adder #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [4*NIBBLES-1:0]   a,
  input  logic [4*NIBBLES-1:0]   b,
  input  logic                   cin,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [4*NIBBLES-1:0]   sum,
  output logic                   cout,
  output logic                   ovf
);

  localparam int DATA_W = 4 * NIBBLES;
  localparam int IDX_W  = $clog2(NIBBLES);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state, state_nxt;
  logic [DATA_W-1:0]  a_q, b_q, sum_q;
  logic               carry_q, cout_q, ovf_q;
  logic [IDX_W-1:0]   idx_q;
  logic               last_nib;

  logic [3:0]         a_nib, b_nib, s_nib;
  logic               c3_nib, c4_nib;
  logic [5:0]         slice;

  // Returns {c4, c3, sum[3:0]}; every carry is a flat sum of products of p/g/c0.
  function automatic logic [5:0] cla4(input logic [3:0] x, input logic [3:0] y,
                                      input logic c0);
    logic [3:0] p, g, s;
    logic       c1, c2, c3, c4;
    p  = x ^ y;
    g  = x & y;
    c1 = g[0] | (p[0] & c0);
    c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
    c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
    c4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
       | (p[3] & p[2] & p[1] & p[0] & c0);
    s  = p ^ {c3, c2, c1, c0};
    return {c4, c3, s};
  endfunction

  assign a_nib    = a_q[{idx_q, 2'b00} +: 4];
  assign b_nib    = b_q[{idx_q, 2'b00} +: 4];
  assign slice    = cla4(a_nib, b_nib, carry_q);
  assign s_nib    = slice[3:0];
  assign c3_nib   = slice[4];
  assign c4_nib   = slice[5];
  assign last_nib = (idx_q == IDX_W'(NIBBLES - 1));

  // Handshake flags depend on state only; rst masks in_ready while held.
  assign in_ready  = (state == IDLE) && !rst;
  assign out_valid = (state == DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid && in_ready) state_nxt = RUN;
      RUN:     if (last_nib)             state_nxt = DONE;
      DONE:    if (out_ready)            state_nxt = IDLE;
      default:                           state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q     <= a;
            b_q     <= b;
            carry_q <= cin;
            idx_q   <= '0;
          end
        end
        RUN: begin
          sum_q[{idx_q, 2'b00} +: 4] <= s_nib;
          carry_q                    <= c4_nib;
          idx_q                      <= idx_q + 1'b1;
          // Top slice: c3 is the carry into bit W-1, c4 the carry out of it.
          if (last_nib) begin
            cout_q <= c4_nib;
            ovf_q  <= c3_nib ^ c4_nib;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Scoreboarded bench for nibble_serial_adder (NIBBLES=4): directed vectors,
// back-pressure, mid-operation reset and a long random run.
module tb_nibble_serial_adder;

  localparam int NIBBLES = 4;
  localparam int W       = 4 * NIBBLES;
  localparam int LAT     = NIBBLES + 1;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a, b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct packed {
    logic [W-1:0] s;
    logic         c;
    logic         o;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  nibble_serial_adder #(.NIBBLES(NIBBLES)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf)
  );

  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic ci);
    logic [W:0] t;
    exp_t       e;
    t   = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
    e.s = t[W-1:0];
    e.c = t[W];
    e.o = (x[W-1] == y[W-1]) && (t[W-1] != x[W-1]);
    return e;
  endfunction

  // Offers one operand set at a negedge, records the expectation on acceptance,
  // then waits for out_valid. lat counts edges from the accepting edge (=1)
  // through the edge that raises out_valid. poke keeps in_valid high with
  // changing operands while the block is busy.
  task automatic drive_op(input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic ci, input bit poke, output int lat);
    int n;
    n        = 0;
    in_valid = 1'b1;
    a        = x;
    b        = y;
    cin      = ci;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      vectors++;
      miscompares++;
      $display("FAIL accept_wait: in_ready=%0b required 1", in_ready);
      in_valid = 1'b0;
      lat      = -1;
      return;
    end
    sb.push_back(model(x, y, ci));
    @(negedge clk);
    lat      = 1;
    in_valid = poke;
    a        = W'($urandom);
    b        = W'($urandom);
    cin      = 1'($urandom);
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
      if (poke) begin
        a = W'($urandom);
        b = W'($urandom);
      end
    end
  endtask

  task automatic release_op();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({sum, cout, ovf, out_valid, in_ready} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: sum=%h cout=%b ovf=%b out_valid=%b in_ready=%b required all 0",
               sum, cout, ovf, out_valid, in_ready);
    end
    rst = 1'b0;
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_release_ready: in_ready=%b required 1", in_ready);
    end
  endtask

  task automatic test_directed();
    logic [W-1:0] ta[4] = '{16'h1234, 16'hFFFF, 16'h4444, 16'h7FFF};
    logic [W-1:0] tb[4] = '{16'h4321, 16'h0001, 16'h4444, 16'h0000};
    logic         tc[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic [W-1:0] ts[4] = '{16'h5555, 16'h0000, 16'h8888, 16'h8000};
    logic         tco[4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic         tov[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    int   lat;
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      drive_op(ta[i], tb[i], tc[i], 1'b0, lat);
      vectors++;
      if (lat != LAT) begin
        miscompares++;
        $display("FAIL dir%0d_latency: got %0d edges required %0d", i, lat, LAT);
      end
      e = (sb.size() > 0) ? sb.pop_front() : '0;
      vectors++;
      if ({sum, cout, ovf} !== {e.s, e.c, e.o}) begin
        miscompares++;
        $display("FAIL dir%0d_model: sum=%h cout=%b ovf=%b required %h %b %b",
                 i, sum, cout, ovf, e.s, e.c, e.o);
      end
      vectors++;
      if ({sum, cout, ovf} !== {ts[i], tco[i], tov[i]}) begin
        miscompares++;
        $display("FAIL dir%0d_literal: sum=%h cout=%b ovf=%b required %h %b %b",
                 i, sum, cout, ovf, ts[i], tco[i], tov[i]);
      end
      release_op();
      vectors++;
      if ({out_valid, in_ready, sum, cout, ovf} !== {1'b0, 1'b1, ts[i], tco[i], tov[i]}) begin
        miscompares++;
        $display("FAIL dir%0d_idle_hold: out_valid=%b in_ready=%b sum=%h required 0 1 %h",
                 i, out_valid, in_ready, sum, ts[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    int   lat;
    int   bad;
    exp_t e;
    drive_op(16'hA5C3, 16'h3C5A, 1'b1, 1'b1, lat);
    vectors++;
    if (lat != LAT) begin
      miscompares++;
      $display("FAIL bp_latency: got %0d edges required %0d", lat, LAT);
    end
    e   = (sb.size() > 0) ? sb.pop_front() : '0;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if ({out_valid, in_ready, sum, cout, ovf} !== {1'b1, 1'b0, e.s, e.c, e.o}) bad++;
      a = W'($urandom);
      b = W'($urandom);
      @(negedge clk);
    end
    vectors++;
    if (bad != 0 || {out_valid, sum, cout, ovf} !== {1'b1, e.s, e.c, e.o}) begin
      miscompares++;
      $display("FAIL bp_hold: %0d bad cycles, sum=%h out_valid=%b required %h 1",
               bad, sum, out_valid, e.s);
    end
    // in_valid is still high across the edge that leaves DONE.
    release_op();
    vectors++;
    if ({out_valid, in_ready, sum} !== {1'b0, 1'b1, e.s}) begin
      miscompares++;
      $display("FAIL bp_leave_no_accept: out_valid=%b in_ready=%b sum=%h required 0 1 %h",
               out_valid, in_ready, sum, e.s);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_abort();
    int   lat;
    int   seen;
    exp_t e;
    in_valid = 1'b1;
    a        = 16'h1111;
    b        = 16'h2222;
    cin      = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    vectors++;
    if ({sum, cout, ovf, out_valid, in_ready} !== '0) begin
      miscompares++;
      $display("FAIL abort_outputs: sum=%h cout=%b ovf=%b out_valid=%b in_ready=%b required all 0",
               sum, cout, ovf, out_valid, in_ready);
    end
    @(negedge clk);
    rst  = 1'b0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    vectors++;
    if (seen != 0) begin
      miscompares++;
      $display("FAIL abort_no_valid: out_valid seen %0d cycles required 0", seen);
    end
    drive_op(16'h0F0F, 16'h00F1, 1'b0, 1'b0, lat);
    e = (sb.size() > 0) ? sb.pop_front() : '0;
    vectors++;
    if (lat != LAT || {sum, cout, ovf} !== {16'h1000, 1'b0, 1'b0} ||
        {sum, cout, ovf} !== {e.s, e.c, e.o}) begin
      miscompares++;
      $display("FAIL abort_recover: lat=%0d sum=%h cout=%b ovf=%b required %0d 1000 0 0",
               lat, sum, cout, ovf, LAT);
    end
    release_op();
  endtask

  task automatic test_random();
    int           lat;
    int           printed;
    exp_t         e;
    logic [W-1:0] x, y;
    logic         ci;
    printed = 0;
    for (int i = 0; i < 10000; i++) begin
      x = W'($urandom);
      y = W'($urandom);
      ci = 1'($urandom);
      drive_op(x, y, ci, 1'b0, lat);
      e = (sb.size() > 0) ? sb.pop_front() : '0;
      if ($urandom_range(0, 7) == 0) begin
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end
      vectors++;
      if (lat != LAT || {out_valid, sum, cout, ovf} !== {1'b1, e.s, e.c, e.o}) begin
        miscompares++;
        if (printed < 10) begin
          printed++;
          $display("FAIL rand%0d: %h+%h+%b lat=%0d sum=%h cout=%b ovf=%b required lat=%0d %h %b %b",
                   i, x, y, ci, lat, sum, cout, ovf, LAT, e.s, e.c, e.o);
        end
        if (lat >= 40 || lat < 0) break;
      end
      release_op();
    end
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_abort();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
